// File: rtl/tohost_pkg.sv
// ============================================================================
// tohost_pkg : shared FSM encoding and tohost command field layout
// Rev 1.0
// ============================================================================
`default_nettype none

package tohost_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [30:0] EXIT_UNSUPPORTED = 31'h7FFF_FFFF;

    localparam int EXIT_BIT = 0;
    localparam int CODE_LSB = 1;
    localparam int CODE_MSB = 31;

endpackage

`default_nettype wire

// File: rtl/tohost_watchdog.sv
// ============================================================================
// tohost_watchdog : saturating 64-bit cycle counter with expiry compare
// Rev 1.0
// ============================================================================
`default_nettype none

module tohost_watchdog #(
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [63:0] count,
    output logic        expire
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= 64'd0;
        end else if (count != {64{1'b1}}) begin
            count <= count + 64'd1;
        end
    end

    // Expiry fires one cycle early so the flag lands exactly TIMEOUT_CYCLES edges after release.
    generate
        if (TIMEOUT_CYCLES == 64'd0) begin : g_wd_off
            logic unused_enable;
            assign unused_enable = enable;
            assign expire        = 1'b0;
        end else begin : g_wd_on
            assign expire = enable && (count == (TIMEOUT_CYCLES - 64'd1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tohost_monitor.sv
// ============================================================================
// tohost_monitor : write sink that decodes tohost writes into pass/fail/exit
// code, with an in-harness watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module tohost_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter logic [63:0]       TIMEOUT_CYCLES = 64'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              io_success,
    output logic              io_failure,
    output logic [30:0]       exit_code,
    output logic              timed_out,
    output logic [63:0]       cycle_count
);

    import tohost_pkg::*;

    state_t      state, state_nxt;
    logic        resp_valid_nxt;
    logic        success_nxt;
    logic        failure_nxt;
    logic        timed_out_nxt;
    logic [30:0] exit_code_nxt;
    logic        accept;
    logic        decode_hit;
    logic        expire;
    logic [31:0] cmd;
    logic [30:0] code;
    logic        unused_data_hi;

    // Only the low word carries the command; upper data bits are don't-care.
    assign cmd            = wr_data[31:0];
    assign code           = cmd[CODE_MSB:CODE_LSB];
    assign unused_data_hi = ^wr_data[DATA_W-1:32];

    assign wr_ready   = reset && (!resp_valid || resp_ready);
    assign accept     = wr_valid && wr_ready;
    assign decode_hit = accept && (wr_addr == TOHOST_ADDR) && (cmd != 32'd0);

    tohost_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (state == RUN),
        .count  (cycle_count),
        .expire (expire)
    );

    always_comb begin
        state_nxt      = state;
        resp_valid_nxt = resp_valid;
        success_nxt    = io_success;
        failure_nxt    = io_failure;
        timed_out_nxt  = timed_out;
        exit_code_nxt  = exit_code;

        if (accept) begin
            resp_valid_nxt = 1'b1;
        end else if (resp_ready) begin
            resp_valid_nxt = 1'b0;
        end

        // A decode on the expiry edge takes priority over the watchdog.
        if (state == RUN) begin
            if (decode_hit) begin
                if (cmd[EXIT_BIT]) begin
                    if (code == 31'd0) begin
                        state_nxt   = PASS;
                        success_nxt = 1'b1;
                    end else begin
                        state_nxt     = FAIL;
                        failure_nxt   = 1'b1;
                        exit_code_nxt = code;
                    end
                end else begin
                    state_nxt     = FAIL;
                    failure_nxt   = 1'b1;
                    exit_code_nxt = EXIT_UNSUPPORTED;
                end
            end else if (expire) begin
                state_nxt     = FAIL;
                failure_nxt   = 1'b1;
                timed_out_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= RUN;
            resp_valid <= 1'b0;
            io_success <= 1'b0;
            io_failure <= 1'b0;
            timed_out  <= 1'b0;
            exit_code  <= 31'd0;
        end else begin
            state      <= state_nxt;
            resp_valid <= resp_valid_nxt;
            io_success <= success_nxt;
            io_failure <= failure_nxt;
            timed_out  <= timed_out_nxt;
            exit_code  <= exit_code_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tohost_monitor.sv
// ============================================================================
// tb_tohost_monitor : directed bench with per-ack flag scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tohost_monitor;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    typedef struct packed {
        logic        s;
        logic        f;
        logic        to;
        logic [30:0] ec;
    } exp_t;

    logic        clock;
    int          tests;
    int          fails;
    exp_t        q0[$];
    exp_t        q1[$];

    logic        rst0, wr_valid0, wr_ready0, resp_valid0, resp_ready0;
    logic [31:0] wr_addr0;
    logic [63:0] wr_data0, cycle_count0;
    logic        io_success0, io_failure0, timed_out0;
    logic [30:0] exit_code0;

    logic        rst1, wr_valid1, wr_ready1, resp_valid1, resp_ready1;
    logic [31:0] wr_addr1;
    logic [63:0] wr_data1, cycle_count1;
    logic        io_success1, io_failure1, timed_out1;
    logic [30:0] exit_code1;

    tohost_monitor #(.TIMEOUT_CYCLES(64'd0)) dut0 (
        .clock(clock), .reset(rst0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .resp_valid(resp_valid0),
        .resp_ready(resp_ready0), .io_success(io_success0), .io_failure(io_failure0),
        .exit_code(exit_code0), .timed_out(timed_out0), .cycle_count(cycle_count0)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(64'd100)) dut1 (
        .clock(clock), .reset(rst1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .resp_valid(resp_valid1),
        .resp_ready(resp_ready1), .io_success(io_success1), .io_failure(io_failure1),
        .exit_code(exit_code1), .timed_out(timed_out1), .cycle_count(cycle_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic s, input logic f, input logic to, input logic [30:0] ec);
        mk = '{s: s, f: f, to: to, ec: ec};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [63:0] d, input exp_t e);
        wr_valid0   = 1'b1;
        wr_addr0    = a;
        wr_data0    = d;
        resp_ready0 = 1'b1;
        q0.push_back(e);
        @(negedge clock);
        chk("wr_ready0_accept", 64'(wr_ready0), 64'd1);
        step();
        wr_valid0 = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid0 === 1'b1 && resp_ready0 === 1'b1) begin
            chk("ack0_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("ack0_flags", 64'({io_success0, io_failure0, timed_out0, exit_code0}), 64'(e));
            end
        end
        if (resp_valid1 === 1'b1 && resp_ready1 === 1'b1) begin
            chk("ack1_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("ack1_flags", 64'({io_success1, io_failure1, timed_out1, exit_code1}), 64'(e));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst0 = 1'b0; wr_valid0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; resp_ready0 = 1'b1;
        rst1 = 1'b0; wr_valid1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; resp_ready1 = 1'b1;

        // Reset state, with a write offered while in reset
        step();
        wr_valid0 = 1'b1;
        wr_addr0  = TOHOST;
        wr_data0  = 64'h1;
        @(negedge clock);
        chk("rst_wr_ready", 64'(wr_ready0), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid0), 64'd0);
        chk("rst_success", 64'(io_success0), 64'd0);
        chk("rst_failure", 64'(io_failure0), 64'd0);
        chk("rst_exit_code", 64'(exit_code0), 64'd0);
        chk("rst_timed_out", 64'(timed_out0), 64'd0);
        chk("rst_cycle_count", cycle_count0, 64'd0);
        step();
        wr_valid0 = 1'b0;
        rst0      = 1'b1;
        step(); step(); step();
        @(negedge clock);
        chk("cycle_count_3", cycle_count0, 64'd3);

        // Unrelated address, zero command and high-only data are all acked without effect
        step();
        wr0(32'h8000_2000, 64'h1, mk(0, 0, 0, 31'd0));
        wr0(TOHOST, 64'h0, mk(0, 0, 0, 31'd0));
        wr0(TOHOST, 64'h1_0000_0000, mk(0, 0, 0, 31'd0));
        @(negedge clock);
        chk("no_flag_success", 64'(io_success0), 64'd0);
        chk("no_flag_failure", 64'(io_failure0), 64'd0);
        step();

        // Backpressure then back-to-back accepts
        resp_ready0 = 1'b0;
        wr_valid0   = 1'b1;
        wr_addr0    = 32'h0;
        wr_data0    = 64'h0;
        q0.push_back(mk(0, 0, 0, 31'd0));
        @(negedge clock);
        chk("bp_first_ready", 64'(wr_ready0), 64'd1);
        step();
        wr_addr0 = 32'h4;
        q0.push_back(mk(0, 0, 0, 31'd0));
        @(negedge clock);
        chk("bp_resp_valid", 64'(resp_valid0), 64'd1);
        chk("bp_ready_low", 64'(wr_ready0), 64'd0);
        step();
        @(negedge clock);
        chk("bp_ready_held", 64'(wr_ready0), 64'd0);
        chk("bp_resp_held", 64'(resp_valid0), 64'd1);
        step();
        resp_ready0 = 1'b1;
        #1;
        chk("bp_ready_release", 64'(wr_ready0), 64'd1);
        step();
        wr_addr0 = 32'h8;
        q0.push_back(mk(0, 0, 0, 31'd0));
        step();
        wr_valid0 = 1'b0;
        step();
        @(negedge clock);
        chk("bp_drained", 64'(resp_valid0), 64'd0);
        step();

        // Pass path, then a failing command after PASS is ignored
        wr0(TOHOST, 64'h1, mk(1, 0, 0, 31'd0));
        @(negedge clock);
        chk("pass_resp_valid", 64'(resp_valid0), 64'd1);
        chk("pass_success", 64'(io_success0), 64'd1);
        chk("pass_failure", 64'(io_failure0), 64'd0);
        chk("pass_exit_code", 64'(exit_code0), 64'd0);
        step();
        wr0(TOHOST, 64'h7, mk(1, 0, 0, 31'd0));
        step();
        @(negedge clock);
        chk("pass_terminal_failure", 64'(io_failure0), 64'd0);

        // Fail path, then a pass command after FAIL is ignored
        step();
        rst0 = 1'b0;
        step();
        rst0 = 1'b1;
        wr0(TOHOST, 64'h7, mk(0, 1, 0, 31'd3));
        @(negedge clock);
        chk("fail_failure", 64'(io_failure0), 64'd1);
        chk("fail_exit_code", 64'(exit_code0), 64'd3);
        chk("fail_success", 64'(io_success0), 64'd0);
        step();
        wr0(TOHOST, 64'h1, mk(0, 1, 0, 31'd3));
        step();
        @(negedge clock);
        chk("fail_terminal_success", 64'(io_success0), 64'd0);

        // Reset while an ack is pending
        step();
        resp_ready0 = 1'b0;
        wr_valid0   = 1'b1;
        wr_addr0    = 32'h0;
        wr_data0    = 64'h0;
        step();
        wr_valid0 = 1'b0;
        @(negedge clock);
        chk("mid_pre_resp_valid", 64'(resp_valid0), 64'd1);
        chk("mid_pre_failure", 64'(io_failure0), 64'd1);
        step();
        rst0 = 1'b0;
        #1;
        chk("mid_wr_ready_in_reset", 64'(wr_ready0), 64'd0);
        step();
        @(negedge clock);
        chk("mid_resp_valid", 64'(resp_valid0), 64'd0);
        chk("mid_failure", 64'(io_failure0), 64'd0);
        chk("mid_exit_code", 64'(exit_code0), 64'd0);
        chk("mid_cycle_count", cycle_count0, 64'd0);
        step();
        rst0        = 1'b1;
        resp_ready0 = 1'b1;
        step();
        @(negedge clock);
        chk("mid_no_ack_after", 64'(resp_valid0), 64'd0);

        // Unsupported syscall command
        step();
        wr0(TOHOST, 64'h10, mk(0, 1, 0, 31'h7FFF_FFFF));
        @(negedge clock);
        chk("sys_exit_code", 64'(exit_code0), 64'h7FFF_FFFF);
        chk("sys_failure", 64'(io_failure0), 64'd1);
        step();

        // Watchdog expiry exactly 100 edges after release
        rst1 = 1'b1;
        for (int i = 0; i < 99; i++) @(posedge clock);
        @(negedge clock);
        chk("wd_count_99", cycle_count1, 64'd99);
        chk("wd_not_yet", 64'(io_failure1), 64'd0);
        @(posedge clock);
        @(negedge clock);
        chk("wd_failure", 64'(io_failure1), 64'd1);
        chk("wd_timed_out", 64'(timed_out1), 64'd1);
        chk("wd_exit_code", 64'(exit_code1), 64'd0);
        chk("wd_success", 64'(io_success1), 64'd0);
        chk("wd_count_100", cycle_count1, 64'd100);

        // Counter saturation from a forced near-maximum load
        force dut1.u_watchdog.count = 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clock);
        #2;
        release dut1.u_watchdog.count;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("wd_saturate", cycle_count1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clock);
        @(negedge clock);
        chk("wd_saturate_hold", cycle_count1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Decode on the expiry edge beats the watchdog
        step();
        rst1 = 1'b0;
        step();
        rst1 = 1'b1;
        for (int i = 0; i < 99; i++) @(posedge clock);
        #2;
        wr_valid1   = 1'b1;
        wr_addr1    = TOHOST;
        wr_data1    = 64'h1;
        resp_ready1 = 1'b1;
        q1.push_back(mk(1, 0, 0, 31'd0));
        @(negedge clock);
        chk("tie_count_99", cycle_count1, 64'd99);
        chk("tie_wr_ready", 64'(wr_ready1), 64'd1);
        step();
        wr_valid1 = 1'b0;
        @(negedge clock);
        chk("tie_success", 64'(io_success1), 64'd1);
        chk("tie_failure", 64'(io_failure1), 64'd0);
        chk("tie_timed_out", 64'(timed_out1), 64'd0);
        step();
        step();

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
- Harness-side producer of the `io_success` signal that the top-level test driver samples every clock.
- Sinks simple write transactions from the DUT's memory/MMIO path and acknowledges every write.
- Decodes writes to the tohost address into pass/fail with an exit code.
- Adds an in-harness cycle watchdog, so failure is flagged independently of the driver's own timeout.

Parameters:
- ADDR_W, 32, width of write address.
- DATA_W, 64, width of write data; must be >= 33.
- TOHOST_ADDR, 32'h8000_1000, address whose writes are decoded.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles after reset release; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clock.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when high together with wr_valid.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- resp_valid  out  1  write acknowledge valid.
- resp_ready  in  1  acknowledge consumed.
- io_success  out  1  sticky pass indication.
- io_failure  out  1  sticky fail indication.
- exit_code  out  31  latched failure code (wr_data[31:1]); 0x7FFF_FFFF marks an unsupported tohost command.
- timed_out  out  1  sticky; set when io_failure was caused by the watchdog.
- cycle_count  out  64  cycles elapsed since reset release.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM = RUN.
  - resp_valid=0, io_success=0, io_failure=0, timed_out=0, exit_code=0, cycle_count=0.
  - A pending ack is dropped.
- wr_ready = !resp_valid || resp_ready. It is combinational, and is forced to 0 while reset==0.
- Write accept:
  - A write is accepted in cycle N when wr_valid && wr_ready.
  - resp_valid rises in N+1 and holds until resp_ready.
  - Back-to-back accepts are allowed when resp_ready is high.
  - Writes to any address are acknowledged; only TOHOST_ADDR writes are decoded.
- Decode (FSM in RUN only, on the accept cycle; flags visible in N+1):
  - data==0: ignored.
  - data[0]==1 && data[31:1]==0: io_success=1, FSM->PASS.
  - data[0]==1 && data[31:1]!=0: io_failure=1, exit_code=data[31:1], FSM->FAIL.
  - data[0]==0 && data!=0 (syscall request, not supported): io_failure=1, exit_code=31'h7FFF_FFFF, FSM->FAIL.
  - Bits above 31 are ignored.
- FSM states: RUN, PASS, FAIL.
  - PASS and FAIL are terminal until reset.
  - In terminal states writes are still accepted and acked but not decoded.
  - Outputs hold their values in terminal states.
- Watchdog:
  - cycle_count increments every non-reset cycle and saturates at 2^64-1.
  - In RUN, when TIMEOUT_CYCLES!=0 and cycle_count == TIMEOUT_CYCLES-1, the next edge sets io_failure=1 and timed_out=1, leaves exit_code=0, and moves FSM->FAIL.
- Simultaneous events: a tohost decode and watchdog expiry on the same edge resolve in favour of the decode; timed_out stays 0.
- io_success and io_failure are never both 1.
- Reset mid-ack: pending resp is discarded, with no ack after reset.

Decomposition:
- Shared package tohost_pkg holds:
  - FSM enum {RUN, PASS, FAIL};
  - constant EXIT_UNSUPPORTED = 31'h7FFF_FFFF;
  - the tohost encoding helper constants: exit bit index 0, code field [31:1].
- Natural sub-module: tohost_watchdog, holding the saturating 64-bit counter and expiry compare. It has inputs clock, reset, enable (FSM==RUN) and outputs count and expire.
- The top level holds the handshake, decode and FSM.

Test Plan:
- Pass path: release reset, write addr 0x8000_1000 data 0x1 -> wr_ready=1; resp_valid=1 and io_success=1 next cycle; io_failure=0; exit_code=0.
- Fail path: write tohost data 0x7 -> io_failure=1, exit_code=3, io_success=0. A later write of 0x1 is acked and io_success stays 0.
- Unrelated and backpressured writes:
  - Write to 0x8000_2000 data 0x1 -> acked, no flag change.
  - Hold resp_ready=0 -> wr_ready=0 until ack consumed; back-to-back accepts with resp_ready=1.
- Watchdog and tie:
  - TIMEOUT_CYCLES=100, no writes -> io_failure=1, timed_out=1 exactly 100 cycles after reset release; cycle_count saturation checked via forced load.
  - Tohost 0x1 accepted on the expiry edge -> io_success=1, timed_out=0.
- Reset behaviour:
  - Assert reset low with resp_valid=1 and io_failure=1 -> next cycle all outputs 0, wr_ready=0 during reset.
  - After release, syscall write data 0x10 -> exit_code=0x7FFF_FFFF, io_failure=1.
